speed_cmd_encoder: RTL and testbench

//  Front-panel command source for speed_controller. Turns raw push-buttons into the

---
 rtl/speed_cmd_encoder.sv | 147 ++++++++++++++
 tb/tb_speed_cmd_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/speed_cmd_encoder.sv
// Front-panel button front end: per-button 2-FF sync, debounce, rising-edge detect,
// and a hold-to-repeat FSM that emits one-cycle speed_up/speed_down/speed_rst pulses.
module speed_cmd_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_rst,
    output logic speed_up,
    output logic speed_down,
    output logic speed_rst,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT, S_RSTWAIT} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Bit order in the per-button vectors: [0]=up, [1]=down, [2]=rst
    logic [2:0]       r_sync1, r_sync2, r_deb, r_deb_prev;
    logic [CNT_W-1:0] r_db_cnt [3];
    logic [2:0]       w_rise;

    state_t           r_state, w_state_nxt;
    logic             r_dir, w_dir_nxt;          // 0 = up, 1 = down
    logic [CNT_W-1:0] r_rep_cnt, w_rep_nxt, w_rep_last;
    logic             r_up, r_dn, r_rst, r_held;
    logic             w_up_nxt, w_dn_nxt, w_rst_nxt, w_held_nxt;
    logic             w_u, w_d, w_r, w_lat, w_opp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_deb_prev <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= {btn_rst, btn_down, btn_up};
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] >= DB_LAST) begin
                    r_deb[i]    <= ~r_deb[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= sat_inc(r_db_cnt[i]);
                end
            end
        end
    end

    assign w_rise     = r_deb & ~r_deb_prev;
    assign w_u        = r_deb[0];
    assign w_d        = r_deb[1];
    assign w_r        = r_deb[2];
    assign w_lat      = r_dir ? w_d : w_u;
    assign w_opp      = r_dir ? w_u : w_d;
    assign w_rep_last = (r_state == S_HOLD) ? DELAY_LAST : PERIOD_LAST;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_rep_nxt   = r_rep_cnt;
        w_up_nxt    = 1'b0;
        w_dn_nxt    = 1'b0;
        w_rst_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise[2]) begin
                    w_rst_nxt   = 1'b1;
                    w_state_nxt = S_RSTWAIT;
                end else if (w_rise[0] && !w_d) begin
                    w_up_nxt    = 1'b1;
                    w_dir_nxt   = 1'b0;
                    w_rep_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end else if (w_rise[1] && !w_u) begin
                    w_dn_nxt    = 1'b1;
                    w_dir_nxt   = 1'b1;
                    w_rep_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (w_r) begin
                    w_rst_nxt   = 1'b1;
                    w_state_nxt = S_RSTWAIT;
                end else if (w_opp || !w_lat) begin
                    // Conflict or release: drop out silently
                    w_state_nxt = S_IDLE;
                end else if (r_rep_cnt >= w_rep_last) begin
                    w_up_nxt    = ~r_dir;
                    w_dn_nxt    = r_dir;
                    w_rep_nxt   = '0;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_rep_nxt   = sat_inc(r_rep_cnt);
                end
            end
            S_RSTWAIT: begin
                if (!(w_u || w_d || w_r)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_held_nxt = (w_state_nxt == S_HOLD) || (w_state_nxt == S_REPEAT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_rep_cnt <= '0;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_rst     <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_rep_cnt <= w_rep_nxt;
            r_up      <= w_up_nxt;
            r_dn      <= w_dn_nxt;
            r_rst     <= w_rst_nxt;
            r_held    <= w_held_nxt;
        end
    end

    assign speed_up   = r_up;
    assign speed_down = r_dn;
    assign speed_rst  = r_rst;
    assign held       = r_held;

endmodule

// File: tb/tb_speed_cmd_encoder.sv
// Directed bench for speed_cmd_encoder with short debounce/repeat timing.
module tb_speed_cmd_encoder;

    logic clk = 1'b0;
    logic rst_n, btn_up, btn_down, btn_rst;
    logic speed_up, speed_down, speed_rst, held;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int onehot_err = 0;
    int up_q[$], dn_q[$], rs_q[$];
    int offs[5] = '{0, 20, 28, 36, 44};
    int n, m, p, q;

    speed_cmd_encoder #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .CNT_W          (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_rst   (btn_rst),
        .speed_up  (speed_up),
        .speed_down(speed_down),
        .speed_rst (speed_rst),
        .held      (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log, indexed by the cycle number of the edge that produced it
    always @(negedge clk) begin
        if (speed_up === 1'b1)   up_q.push_back(cyc);
        if (speed_down === 1'b1) dn_q.push_back(cyc);
        if (speed_rst === 1'b1)  rs_q.push_back(cyc);
        if ((speed_up + speed_down + speed_rst) > 1) onehot_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic clear_log();
        up_q.delete();
        dn_q.delete();
        rs_q.delete();
    endtask

    task automatic pulse_at(input string tag, input int got_sz, input int got_cyc, input int exp_cyc);
        check({tag, "_cnt"}, got_sz, 1);
        check({tag, "_cyc"}, (got_sz > 0) ? got_cyc : -1, exp_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_rst = 1'b0;

        // Reset state and quiet idle
        tick(3);
        @(negedge clk);
        check("rst_up", speed_up, 0);
        check("rst_dn", speed_down, 0);
        check("rst_rs", speed_rst, 0);
        check("rst_held", held, 0);
        tick(1);
        rst_n = 1'b1;
        clear_log();
        tick(50);
        check("idle_pulses", up_q.size() + dn_q.size() + rs_q.size(), 0);

        // Glitch of 3 cycles rejected
        clear_log();
        btn_up = 1'b1; tick(3); btn_up = 1'b0;
        tick(20);
        check("glitch_pulses", up_q.size() + dn_q.size() + rs_q.size(), 0);
        check("glitch_held", held, 0);

        // Press, hold-to-repeat, release
        clear_log();
        n = cyc; btn_up = 1'b1;
        wait_until(n + 8);
        @(negedge clk);
        check("t3_held_on", held, 1);
        wait_until(n + 48);
        btn_up = 1'b0;
        tick(30);
        check("t3_up_cnt", up_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t3_up_off%0d", i), (i < up_q.size()) ? up_q[i] - (n + 7) : -1, offs[i]);
        check("t3_other", dn_q.size() + rs_q.size(), 0);
        @(negedge clk);
        check("t3_held_off", held, 0);

        // Opposite button during repeat cancels
        tick(1);
        clear_log();
        m = cyc; btn_down = 1'b1;
        wait_until(m + 30);
        btn_up = 1'b1;
        @(negedge clk);
        check("t4_held_rep", held, 1);
        wait_until(m + 60);
        check("t4_dn_cnt", dn_q.size(), 3);
        check("t4_dn_last", (dn_q.size() > 0) ? dn_q[dn_q.size()-1] - m : -1, 35);
        check("t4_up_cnt", up_q.size(), 0);
        @(negedge clk);
        check("t4_held", held, 0);
        tick(1);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(20);
        check("t4_release", up_q.size() + rs_q.size(), 0);

        // Reset button overrides repeat, then down press works
        clear_log();
        p = cyc; btn_up = 1'b1;
        wait_until(p + 30);
        btn_rst = 1'b1;
        wait_until(p + 60);
        check("t5_up_cnt", up_q.size(), 3);
        pulse_at("t5_rst", rs_q.size(), (rs_q.size() > 0) ? rs_q[0] - p : -1, 37);
        @(negedge clk);
        check("t5_held", held, 0);
        tick(1);
        btn_up = 1'b0; btn_rst = 1'b0;
        tick(15);
        clear_log();
        q = cyc; btn_down = 1'b1;
        wait_until(q + 10);
        btn_down = 1'b0;
        tick(15);
        pulse_at("t5_dn", dn_q.size(), (dn_q.size() > 0) ? dn_q[0] - q : -1, 7);
        check("t5_other", up_q.size() + rs_q.size(), 0);

        // Simultaneous up and down rise
        clear_log();
        btn_up = 1'b1; btn_down = 1'b1;
        tick(40);
        check("t6_pulses", up_q.size() + dn_q.size() + rs_q.size(), 0);
        @(negedge clk);
        check("t6_held", held, 0);
        tick(1);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(15);
        check("t6_after", up_q.size() + dn_q.size() + rs_q.size(), 0);

        check("onehot", onehot_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
